seq_div: RTL and testbench

- Multi-cycle integer divide/remainder unit for the core's execute stage.
- Takes the two 32-bit operands after forwarding.
- Its result feeds the writeback result-select mux as an extra input.
- Stalls issue via busy; a fixed-latency radix-2 restoring algorithm performs one quotient bit per cycle.

---
 rtl/core_pkg.sv | 27 ++
 rtl/seq_div_if.sv | 18 +
 rtl/div_step.sv | 25 ++
 rtl/seq_div.sv | 126 ++++++++++++
 tb/tb_seq_div.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types for the execute-stage integer divider: operation codes and FSM states.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } divop_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } div_state_t;

    function automatic logic op_signed(input divop_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input divop_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/seq_div_if.sv
// Issue/result bundle between the execute stage and the divider.
interface seq_div_if
    import core_pkg::*;
#(
    parameter int WIDTH = XLEN
);
    logic             start;
    logic             kill;
    divop_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, kill, op, a, b, input busy, done, result);
    modport slave  (input start, kill, op, a, b, output busy, done, result);
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract divisor, commit on no borrow.
module div_step
    import core_pkg::*;
#(
    parameter int WIDTH = XLEN
)
(
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0]   w_shr;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;

    assign w_shr  = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
    assign w_diff = {1'b0, w_shr} - {2'b00, i_divisor};
    // A set top bit means the shifted value exceeds any divisor, so no borrow is possible.
    assign w_borrow = w_diff[WIDTH+1] & ~i_rem[WIDTH];

    assign o_rem = w_borrow ? w_shr : w_diff[WIDTH:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};
endmodule

// File: rtl/seq_div.sv
// Signed/unsigned divide and remainder, fixed WIDTH+1 cycles from accept to done.
// start is taken only in IDLE; kill aborts an in-flight op and suppresses done.
module seq_div
    import core_pkg::*;
#(
    parameter int WIDTH = XLEN
)
(
    input  logic     clk,
    input  logic     rst,
    seq_div_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       r_state, w_next;
    divop_t           r_op;
    logic             r_sa, r_sb, r_dz;
    logic [WIDTH-1:0] r_a, r_div, r_quo, r_result;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;

    logic             w_sa, w_sb, w_accept;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_quo_nxt, w_q_fix, w_r_fix, w_fix;
    logic [WIDTH:0]   w_rem_nxt;

    assign w_sa     = op_signed(bus.op) & bus.a[WIDTH-1];
    assign w_sb     = op_signed(bus.op) & bus.b[WIDTH-1];
    assign w_mag_a  = w_sa ? -bus.a : bus.a;
    assign w_mag_b  = w_sb ? -bus.b : bus.b;
    assign w_accept = (r_state == IDLE) && bus.start && !bus.kill;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    // Divide-by-zero returns all ones / the original dividend, independent of signs.
    assign w_q_fix = r_dz ? '1  : ((r_sa ^ r_sb) ? -r_quo : r_quo);
    assign w_r_fix = r_dz ? r_a : (r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);
    assign w_fix   = op_is_rem(r_op) ? w_r_fix : w_q_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.result = r_result;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (bus.kill) begin
                    w_next = IDLE;
                end else if (r_cnt == LAST) begin
                    w_next = FIN;
                end
            end
            FIN: begin
                bus.busy = 1'b1;
                w_next   = IDLE;
                if (!bus.kill) begin
                    bus.done   = 1'b1;
                    bus.result = w_fix;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= DIV;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_a      <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.op;
                        r_sa  <= w_sa;
                        r_sb  <= w_sb;
                        r_dz  <= (bus.b == '0);
                        r_a   <= bus.a;
                        r_div <= w_mag_b;
                        r_quo <= w_mag_a;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                FIN: begin
                    if (!bus.kill) begin
                        r_result <= w_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: countdown reference model checked every cycle, directed literal cases, random traffic.
module tb_seq_div;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst;

    seq_div_if #(.WIDTH(32)) dif ();

    seq_div #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: divide magnitudes, then apply truncating-division sign rules.
    function automatic logic [31:0] div_ref(input divop_t op, input logic [31:0] a, input logic [31:0] b);
        bit          sgn;
        bit          sa, sb;
        logic [31:0] ma, mb, q, r;
        sgn = (op == DIV) || (op == REM);
        sa  = sgn && a[31];
        sb  = sgn && b[31];
        ma  = sa ? (32'd0 - a) : a;
        mb  = sb ? (32'd0 - b) : b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = ma / mb;
            r = ma % mb;
            if (sa ^ sb) q = 32'd0 - q;
            if (sa)      r = 32'd0 - r;
        end
        return ((op == REM) || (op == REMU)) ? r : q;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: cycles left until done (0 = idle), pending value, and held result.
    int          m_left   = 0;
    logic [31:0] m_pend   = '0;
    logic [31:0] m_result = '0;
    bit          m_armed  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left   = 0;
            m_result = '0;
            m_armed  = 1'b1;
        end else if (m_left == 0) begin
            if (dif.start && !dif.kill) begin
                m_left = 33;
                m_pend = div_ref(dif.op, dif.a, dif.b);
            end
        end else if (dif.kill) begin
            m_left = 0;
        end else if (m_left == 1) begin
            m_result = m_pend;
            m_left   = 0;
        end else begin
            m_left--;
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            logic        e_busy, e_done;
            logic [31:0] e_res;
            e_busy = (m_left != 0);
            e_done = (m_left == 1) && !dif.kill;
            e_res  = e_done ? m_pend : m_result;
            checks++;
            if (dif.busy !== e_busy || dif.done !== e_done || dif.result !== e_res) begin
                failures++;
                $display("FAIL cycle t=%0t busy=%b/%b done=%b/%b result=%h/%h (got/expected)",
                         $time, dif.busy, e_busy, dif.done, e_done, dif.result, e_res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; optionally inject start(1)/kill(2)/rst(3) in cycle inj_cyc counted from acceptance.
    task automatic run(input string name, input divop_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int inj_cyc, input int inj_kind);
        logic [31:0] res_before, res;
        bit          seen;
        int          lat;
        res_before = dif.result;
        res        = '0;
        seen       = 1'b0;
        lat        = -1;
        dif.op     = op;
        dif.a      = a;
        dif.b      = b;
        dif.start  = 1'b1;
        tick();
        dif.start  = 1'b0;
        dif.a      = $urandom;
        dif.b      = $urandom;
        for (int n = 1; n <= 40 && !seen; n++) begin
            if (n == inj_cyc) begin
                if (inj_kind == 1) begin
                    dif.start = 1'b1;
                    dif.op    = DIV;
                    dif.a     = 32'd5;
                    dif.b     = 32'd1;
                end
                if (inj_kind == 2) dif.kill = 1'b1;
                if (inj_kind == 3) rst = 1'b1;
            end else if (n == inj_cyc + 1) begin
                dif.start = 1'b0;
                dif.kill  = 1'b0;
                rst       = 1'b0;
            end
            @(negedge clk);
            if (inj_kind == 3 && n == inj_cyc + 1) begin
                check({name, "_rst_busy"},   32'(dif.busy), 32'd0);
                check({name, "_rst_done"},   32'(dif.done), 32'd0);
                check({name, "_rst_result"}, dif.result,    32'd0);
            end
            if (dif.done) begin
                seen = 1'b1;
                lat  = n;
                res  = dif.result;
            end
            tick();
        end
        dif.start = 1'b0;
        dif.kill  = 1'b0;
        rst       = 1'b0;
        if (inj_kind == 2 || inj_kind == 3) begin
            check({name, "_no_done"}, 32'(seen), 32'd0);
            check({name, "_hold"}, dif.result, (inj_kind == 3) ? 32'd0 : res_before);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'd33);
            check({name, "_result"}, res, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(1, 15);
            4:       return 32'd0 - $urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        dif.start = 1'b0;
        dif.kill  = 1'b0;
        dif.op    = DIV;
        dif.a     = '0;
        dif.b     = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   32'(dif.busy), 32'd0);
        check("reset_done",   32'(dif.done), 32'd0);
        check("reset_result", dif.result,    32'd0);
        tick();

        check("model_divu",   div_ref(DIVU, 32'd100, 32'd7), 32'd14);
        check("model_rem",    div_ref(REM, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
        check("model_div",    div_ref(DIV, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
        check("model_dz_div", div_ref(DIV, 32'hFFFF_FFFB, 32'd0), 32'hFFFF_FFFF);
        check("model_dz_rem", div_ref(REMU, 32'h1234_5678, 32'd0), 32'h1234_5678);
        check("model_ovf_q",  div_ref(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model_ovf_r",  div_ref(REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

        run("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 0, 0);
        repeat (4) tick();
        check("divu_hold5", dif.result, 32'd14);
        run("rem_m100_7",  REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0, 0);
        run("div_m100_7",  DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 0);
        run("dz_div",      DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0, 0);
        run("dz_remu",     REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 0, 0);
        run("ovf_div",     DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        run("ovf_rem",     REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0);
        run("start_busy",  DIVU, 32'd1000, 32'd10, 32'd100, 10, 1);
        run("kill20",      DIV,  32'd77, 32'd3, 32'd0, 20, 2);
        run("after_kill",  DIVU, 32'd50, 32'd5, 32'd10, 0, 0);
        run("rst15",       REMU, 32'd1234, 32'd100, 32'd0, 15, 3);

        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            dif.start = ($urandom_range(0, 2) == 0);
            dif.kill  = ($urandom_range(0, 29) == 0);
            dif.op    = divop_t'($urandom_range(0, 3));
            dif.a     = pick();
            dif.b     = pick();
            tick();
        end
        rst       = 1'b0;
        dif.start = 1'b0;
        dif.kill  = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
